am_modulator: RTL and testbench

AM_MODULATOR -- requirements
Module: am_modulator

---
 rtl/am_modulator.sv | 79 +++++++
 tb/tb_am_modulator.sv | 110 +++++++++++
 2 files changed

// File: rtl/am_modulator.sv
// am_modulator: AM modulator y = (1 + m*x) * cos(carrier phase) in Q16.16,
// computed over a five-state handshake FSM with a 16-entry cosine LUT.
module am_modulator #(
  parameter logic [15:0] PHASE_STEP = 16'h1000,
  parameter logic [31:0] MOD_INDEX  = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] x_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y_out,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [2:0] {IDLE, MUL_IDX, ENV, MUL_CAR, HOLD} state_t;
  localparam logic [31:0] LUT [16] = '{
    32'h00010000, 32'h0000EC83, 32'h0000B505, 32'h000061F8,
    32'h00000000, 32'hFFFF9E08, 32'hFFFF4AFB, 32'hFFFF137D,
    32'hFFFF0000, 32'hFFFF137D, 32'hFFFF4AFB, 32'hFFFF9E08,
    32'h00000000, 32'h000061F8, 32'h0000B505, 32'h0000EC83
  };
  state_t state, state_nx;
  logic [15:0] phase;
  logic [31:0] x_r, car, p1, env;
  // Clamp a 64-bit signed value into the 32-bit signed range.
  function automatic logic [31:0] sat64(input logic signed [63:0] v);
    return (v[63:31] == {33{v[63]}}) ? v[31:0] : (v[63] ? 32'h80000000 : 32'h7FFFFFFF);
  endfunction
  function automatic logic [31:0] qmul(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [63:0] pr;
    pr = 64'(a) * 64'(b);
    return sat64(pr >>> 16);
  endfunction
  function automatic logic [31:0] add_one(input logic signed [31:0] a);
    return sat64(64'(a) + 64'sh10000);
  endfunction
  assign in_ready = state == IDLE;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? MUL_IDX : IDLE;
      MUL_IDX: state_nx = ENV;
      ENV:     state_nx = MUL_CAR;
      MUL_CAR: state_nx = HOLD;
      HOLD:    state_nx = out_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= '0;
      x_r       <= '0;
      car       <= '0;
      p1        <= '0;
      env       <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_r   <= x_in;
          car   <= LUT[phase[15:12]];
          phase <= phase + PHASE_STEP;
        end
        MUL_IDX: p1 <= qmul(MOD_INDEX, x_r);
        ENV:     env <= add_one(p1);
        MUL_CAR: begin
          y_out     <= qmul(env, car);
          out_valid <= 1'b1;
        end
        HOLD:    if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_am_modulator.sv
// tb_am_modulator: directed checks of am_modulator with default and doubled modulation index.
module tb_am_modulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] x_in = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [31:0] y_out, y_out2;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] lut_exp [16] = '{
    32'h00010000, 32'h0000EC83, 32'h0000B505, 32'h000061F8,
    32'h00000000, 32'hFFFF9E08, 32'hFFFF4AFB, 32'hFFFF137D,
    32'hFFFF0000, 32'hFFFF137D, 32'hFFFF4AFB, 32'hFFFF9E08,
    32'h00000000, 32'h000061F8, 32'h0000B505, 32'h0000EC83
  };
  always #5 clk = ~clk;
  am_modulator dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready)
  );
  am_modulator #(.MOD_INDEX(32'h00020000)) dut2 (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready2),
    .y_out(y_out2), .out_valid(out_valid2), .out_ready(out_ready)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask
  // One sample: valid must be low for the two edges after acceptance and high after the third.
  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] e1, input logic [31:0] e2);
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    x_in = x;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check({tag, ":early_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, ":out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ":y"}, y_out, e1);
    check({tag, ":y2"}, y_out2, e2);
    tick();
    check({tag, ":valid_clr"}, 32'(out_valid), 32'd0);
  endtask
  initial begin
    do_reset();
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:y", y_out, 32'd0);
    check("rst:in_ready", 32'(in_ready), 32'd1);
    run("basic", 32'h00008000, 32'h00014000, 32'h00020000);
    run("step", 32'h00000000, 32'h0000EC83, 32'h0000EC83);
    do_reset();
    run("neg", 32'hFFFC8000, 32'hFFFF4000, 32'hFFFA0000);
    do_reset();
    run("sat", 32'h7FFFFFFF, 32'h4000FFFF, 32'h7FFFFFFF);
    do_reset();
    for (int k = 0; k < 17; k++)
      run($sformatf("lut%0d", k), 32'h0, lut_exp[k % 16], lut_exp[k % 16]);
    do_reset();
    x_in = 32'h00008000;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    x_in = 32'h00000000;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d:out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d:y", k), y_out, 32'h00014000);
      check($sformatf("bp%0d:in_ready", k), 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp:release", 32'(out_valid), 32'd0);
    run("bp_phase", 32'h00000000, 32'h0000EC83, 32'h0000EC83);
    x_in = 32'h00008000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("midrst%0d:out_valid", k), 32'(out_valid), 32'd0);
      tick();
    end
    check("midrst:in_ready", 32'(in_ready), 32'd1);
    run("midrst_phase", 32'h00000000, 32'h00010000, 32'h00010000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
